// File: rtl/multicycle_sequencer.sv
// Central control FSM for the multicycle MIPS core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM, WB, JUMP and PCUPD.
// Each stage unit gets a level enable and is waited on through its done flag.
// Ports:
//   clk, rst                        clock, async active-high reset
//   start, stop                     leave IDLE / return to IDLE after retire
//   instr                           instruction word, valid with fetch_done
//   branch_taken                    ALU compare result, valid with alu_done
//   *_done                          unit completion flags (level)
//   *_en, jump                      unit enables (jump mirrors jump_en)
//   path_index                      decoded instruction class
//   pc_we, pc_src                   PC write strobe and source select
//   busy, error, err_code           status and sticky fault reporting
//   instr_count                     retired-instruction counter
module multicycle_sequencer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      instr,
    input  logic             branch_taken,
    input  logic             fetch_done,
    input  logic             alu_done,
    input  logic             mem_done,
    input  logic             wb_done,
    input  logic             jump_done,
    output logic             fetch_en,
    output logic             alu_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             jump_en,
    output logic             jump,
    output logic [3:0]       path_index,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             busy,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned TMO_W = 16;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_JUMP, S_PCUPD, S_HALT
    } state_t;

    state_t            state, next_state;
    logic [5:0]        op_q, fn_q;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [3:0]        decode_c;
    logic              wait_c, unit_done_c, accept_c, expire_c;
    logic [1:0]        next_err_c, pc_src_c;
    logic              unused_c;

    // Only opcode and funct take part in sequencing.
    assign unused_c = ^instr[25:6];

    // Instruction class from opcode/funct.
    function automatic logic [3:0] decode(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] p;
        case (op)
            6'h00:                             p = (fn == 6'h08) ? 4'd8 : 4'd0;
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: p = 4'd1;
            6'h23:                             p = 4'd2;
            6'h2B:                             p = 4'd3;
            6'h04, 6'h05:                      p = 4'd4;
            6'h02:                             p = 4'd5;
            6'h03:                             p = 4'd6;
            default:                           p = 4'd15;
        endcase
        return p;
    endfunction

    assign decode_c = decode(op_q, fn_q);

    // Done of the unit owning the current wait state; done is ignored in
    // the entry cycle (tmo_cnt == 0), and done at the limit beats timeout.
    always_comb begin
        wait_c      = 1'b1;
        unit_done_c = 1'b0;
        case (state)
            S_FETCH: unit_done_c = fetch_done;
            S_EXEC:  unit_done_c = alu_done;
            S_MEM:   unit_done_c = mem_done;
            S_WB:    unit_done_c = wb_done;
            S_JUMP:  unit_done_c = jump_done;
            default: wait_c      = 1'b0;
        endcase
        accept_c = wait_c && unit_done_c && (tmo_cnt != '0);
        expire_c = wait_c && !accept_c && (tmo_cnt == TMO_LAST);
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        next_err_c = 2'd0;
        case (state)
            S_IDLE:   if (start) next_state = S_FETCH;
            S_FETCH:  if (accept_c) next_state = S_DECODE;
            S_DECODE: begin
                case (decode_c)
                    4'd15: begin
                        next_state = S_HALT;
                        next_err_c = 2'd1;
                    end
                    4'd5, 4'd6, 4'd8: next_state = S_JUMP;
                    default:          next_state = S_EXEC;
                endcase
            end
            S_EXEC: if (accept_c) begin
                case (path_index)
                    4'd2, 4'd3: next_state = S_MEM;
                    4'd4:       next_state = S_PCUPD;
                    default:    next_state = S_WB;
                endcase
            end
            S_MEM:   if (accept_c) next_state = (path_index == 4'd2) ? S_WB : S_PCUPD;
            S_WB:    if (accept_c) next_state = S_PCUPD;
            S_JUMP:  if (accept_c) next_state = (path_index == 4'd6) ? S_WB : S_PCUPD;
            S_PCUPD: next_state = stop ? S_IDLE : S_FETCH;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_IDLE;
        endcase
        if (expire_c) begin
            next_state = S_HALT;
            next_err_c = 2'd2;
        end
    end

    // PC source chosen on entry to PCUPD; path 4 reaches PCUPD straight
    // from the alu_done cycle, so branch_taken is still valid here.
    always_comb begin
        pc_src_c = 2'd0;
        case (path_index)
            4'd5, 4'd6, 4'd8: pc_src_c = 2'd2;
            4'd4:             pc_src_c = branch_taken ? 2'd1 : 2'd0;
            default:          pc_src_c = 2'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Registered Moore outputs and datapath state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_en    <= 1'b0;
            alu_en      <= 1'b0;
            mem_en      <= 1'b0;
            wb_en       <= 1'b0;
            jump_en     <= 1'b0;
            jump        <= 1'b0;
            pc_we       <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'd0;
            pc_src      <= 2'd0;
            path_index  <= 4'd0;
            instr_count <= '0;
            tmo_cnt     <= '0;
            op_q        <= 6'd0;
            fn_q        <= 6'd0;
        end else begin
            fetch_en <= (next_state == S_FETCH);
            alu_en   <= (next_state == S_EXEC);
            mem_en   <= (next_state == S_MEM);
            wb_en    <= (next_state == S_WB);
            jump_en  <= (next_state == S_JUMP);
            jump     <= (next_state == S_JUMP);
            pc_we    <= (next_state == S_PCUPD);
            busy     <= (next_state != S_IDLE) && (next_state != S_HALT);

            if (next_state != state) tmo_cnt <= '0;
            else if (wait_c)         tmo_cnt <= tmo_cnt + TMO_W'(1);

            if (state == S_FETCH && accept_c) begin
                op_q <= instr[31:26];
                fn_q <= instr[5:0];
            end

            if (state == S_DECODE) path_index <= decode_c;

            if (next_state == S_PCUPD) begin
                pc_src      <= pc_src_c;
                instr_count <= instr_count + CNT_W'(1);
            end

            if (next_state == S_HALT && state != S_HALT) begin
                error    <= 1'b1;
                err_code <= next_err_c;
            end
        end
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Central control FSM for the multicycle MIPS core. Steps each instruction through fetch, decode, execute, memory, writeback, jump and PC-update phases.
- Decodes opcode/funct into the shared path_index code used by the stage units.
- Drives each unit with a level enable and waits for that unit's done flag.
- Detects illegal opcodes and hung units, counts retired instructions.

Parameters:
- TIMEOUT, 255, max cycles an enable may stay high without its done before error (1..65535)
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE and begin executing
- stop  in  1  return to IDLE after the current instruction retires
- instr  in  32  instruction word, valid while fetch_done=1
- branch_taken  in  1  ALU compare result, valid while alu_done=1
- fetch_done, alu_done, mem_done, wb_done, jump_done  in  1 each  unit completion flags (level)
- fetch_en, alu_en, mem_en, wb_en, jump_en  out  1 each  unit enables (level)
- jump  out  1  jump request to jump unit, equals jump_en
- path_index  out  4  decoded instruction class
- pc_we  out  1  one-cycle PC write strobe
- pc_src  out  2  0=PC+1, 1=branch target, 2=jump unit pc_out
- busy  out  1  FSM not in IDLE/HALT
- error  out  1  sticky fault flag
- err_code  out  2  0=none, 1=illegal opcode, 2=timeout
- instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (async, immediate, including mid-instruction):
  - state=IDLE; all *_en, jump, pc_we, busy, error = 0.
  - path_index=0, pc_src=0, err_code=0, instr_count=0, timeout counter=0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, JUMP, PCUPD, HALT. Registered outputs, Moore style.
- IDLE: start=1 -> FETCH next cycle.
- Wait-state handshake (FETCH/EXEC/MEM/WB/JUMP):
  - The matching en is high for the whole state.
  - The first cycle its done is sampled 1: en drops and the FSM advances.
  - Done is ignored in the entry cycle, so each handshake takes at least 2 cycles.
  - Done from a non-matching unit is ignored.
- FETCH: on fetch_done, latch instr.
- DECODE (1 cycle): register path_index from the latched instr:
  - opcode 0, funct 0x08 -> 8 (jr)
  - opcode 0, other funct -> 0
  - opcodes 0x08, 0x0A, 0x0C, 0x0D, 0x0F -> 1
  - 0x23 -> 2; 0x2B -> 3; 0x04 or 0x05 -> 4; 0x02 -> 5; 0x03 -> 6
  - anything else -> 15
  - path_index holds until the next DECODE.
- Phase sequence after DECODE:
  - 0, 1: EXEC, WB, PCUPD
  - 2: EXEC, MEM, WB, PCUPD
  - 3: EXEC, MEM, PCUPD
  - 4: EXEC, PCUPD; branch_taken is latched at alu_done
  - 5, 8: JUMP, PCUPD
  - 6: JUMP, WB, PCUPD
  - 15: HALT with error=1, err_code=1; no pc_we, no count.
- PCUPD (1 cycle): pc_we=1.
  - pc_src = 2 for paths 5/6/8; 1 for path 4 when taken; else 0.
  - instr_count increments and wraps at 2^CNT_W.
  - Next state: IDLE if stop=1 this cycle, else FETCH.
- Minimum latencies, FETCH entry to PCUPD inclusive: path 0 = 8 cycles; path 5 = 6 cycles.
- Timeout:
  - A counter clears on entry to each wait state and increments each cycle done is low.
  - On reaching TIMEOUT: drop all enables, go to HALT, error=1, err_code=2.
  - Done arriving in the same cycle the count hits TIMEOUT wins; no error.
- HALT: all enables 0, busy=0, error and err_code held. Exit only via rst; start is ignored.
- start while busy: ignored.
- stop sampled outside PCUPD: no effect.

Test Plan:
- add (opcode 0, funct 0x20); every done asserted 1 cycle after its en -> path_index=0; enable order fetch, alu, wb; one pc_we with pc_src=0; instr_count=1; 8 cycles FETCH-to-PCUPD.
- Back-to-back j 0x0000010 then jr (funct 0x08) -> path_index 5 then 8; jump_en and jump high in both; pc_src=2 at each PCUPD; alu_en, mem_en and wb_en never rise.
- beq with branch_taken=1, then bne with branch_taken=0 -> pc_src=1 then 0; lw shows mem_en then wb_en; sw shows mem_en, no wb_en; jal shows jump_en then wb_en.
- Opcode 0x3F -> HALT, error=1, err_code=1, busy=0, no pc_we, instr_count unchanged; a later start pulse is ignored.
- TIMEOUT=8, mem_done stuck at 0 on lw -> mem_en high exactly 8 cycles, then error=1, err_code=2. Repeat with mem_done arriving on cycle 8 -> no error.
- rst pulsed mid-EXEC -> all enables 0 at once, instr_count=0, state IDLE. stop=1 during PCUPD -> IDLE, busy=0, start resumes at FETCH.
